// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared definitions for the Viterbi loop frame controller.
//   vfc_state_t        frame sequencer states
//   PRBS7_TAP_HI/LO    feedback taps of x^7+x^6+1 (bit 6 ^ bit 5)
//   PRBS7_DEFAULT_SEED nonzero seed used at reset and in place of a zero seed
//   ERR_MASK_A/B       alternating channel error masks
//   prbs7_next()       one left-shift step of the PRBS-7 generator
package viterbi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } vfc_state_t;

    localparam int         PRBS7_TAP_HI       = 6;
    localparam int         PRBS7_TAP_LO       = 5;
    localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;

    localparam logic [1:0] ERR_MASK_A = 2'b01;
    localparam logic [1:0] ERR_MASK_B = 2'b10;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/viterbi_prbs7.sv
// viterbi_prbs7: PRBS-7 (x^7+x^6+1) generator, left shifting.
// Ports:
//   clk, rst    clock, asynchronous active-low reset (state -> 7'h7F)
//   load_i      load seed_i (takes priority over advance_i)
//   seed_i      7-bit seed
//   advance_i   step the generator one position
//   state_o     current 7-bit generator state
module viterbi_prbs7
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [6:0] seed_i,
    input  logic       advance_i,
    output logic [6:0] state_o
);

    logic [6:0] state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           state_q <= PRBS7_DEFAULT_SEED;
        else if (load_i)    state_q <= seed_i;
        else if (advance_i) state_q <= prbs7_next(state_q);
    end

    assign state_o = state_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer and self-checker for the
// encoder -> channel -> Viterbi decoder loop. One frame per accepted start:
// FRAME_LEN PRBS-7 payload bits, TAIL_LEN zero flush bits, DEC_LATENCY drain
// cycles, then a one-cycle done pulse.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_i         frame start pulse (ignored unless idle)
//   seed_i          PRBS seed, sampled on accepted start (0 -> 7'h7F)
//   busy_o, done_o  frame in progress / end-of-frame pulse
//   enc_enable_o    encoder enable (payload + tail)
//   enc_data_o      encoder input bit
//   err_mask_o      channel XOR mask, one cycle behind its encoder symbol
//   decoder_i       decoded bit, DEC_LATENCY cycles behind enc_data_o
//   bit_err_ct_o    payload bits that came back wrong (saturating)
//   inj_err_ct_o    errors injected this frame (saturating)
// Build option: VITERBI_FRAME_CTRL_ERR_INJ_EN enables channel error
// scheduling; without it err_mask_o and inj_err_ct_o are tied to zero.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN   = 64,
    parameter int TAIL_LEN    = 2,
    parameter int DEC_LATENCY = 16,
    parameter int ERR_PERIOD  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [6:0]  seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        enc_enable_o,
    output logic        enc_data_o,
    output logic [1:0]  err_mask_o,
    input  logic        decoder_i,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_err_ct_o
);

    localparam logic [15:0] PAY_LAST   = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TAIL_LAST  = 16'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
    localparam logic [15:0] DRAIN_LAST = 16'(DEC_LATENCY - 1);
    localparam bit          HAS_TAIL   = (TAIL_LEN > 0);

    vfc_state_t                  state_q;
    logic [15:0]                 cnt_q;
    logic                        busy_q, done_q, enc_en_q, enc_data_q;
    logic [15:0]                 bit_err_q;
    logic [DEC_LATENCY-1:0][1:0] ref_q;   // {payload flag, bit} per cycle
    logic [6:0]                  lfsr_q, lfsr_nxt, seed_eff;
    logic                        accept, head_flag, head_bit;

    assign accept   = (state_q == S_IDLE) && start_i;
    assign seed_eff = (seed_i == 7'd0) ? PRBS7_DEFAULT_SEED : seed_i;
    assign lfsr_nxt = prbs7_next(lfsr_q);

    // lfsr_q holds the state whose bit 6 is on enc_data_o during PAYLOAD.
    viterbi_prbs7 u_prbs (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .seed_i    (seed_eff),
        .advance_i (state_q == S_PAYLOAD),
        .state_o   (lfsr_q)
    );

    // Outputs are set on the edge that enters a state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            enc_en_q   <= 1'b0;
            enc_data_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q    <= S_PAYLOAD;
                    cnt_q      <= '0;
                    busy_q     <= 1'b1;
                    enc_en_q   <= 1'b1;
                    enc_data_q <= seed_eff[6];
                end
                S_PAYLOAD: if (cnt_q == PAY_LAST) begin
                    cnt_q      <= '0;
                    enc_data_q <= 1'b0;
                    if (HAS_TAIL) begin
                        state_q <= S_TAIL;
                    end else begin
                        state_q  <= S_DRAIN;
                        enc_en_q <= 1'b0;
                    end
                end else begin
                    cnt_q      <= cnt_q + 16'd1;
                    enc_data_q <= lfsr_nxt[6];
                end
                S_TAIL: if (cnt_q == TAIL_LAST) begin
                    state_q  <= S_DRAIN;
                    cnt_q    <= '0;
                    enc_en_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                S_DRAIN: if (cnt_q == DRAIN_LAST) begin
                    state_q <= S_DONE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    busy_q   <= 1'b0;
                    enc_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Reference delay line: the head is the bit presented DEC_LATENCY cycles ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q <= '0;
        end else begin
            ref_q[0] <= {state_q == S_PAYLOAD, enc_data_q};
            for (int i = 1; i < DEC_LATENCY; i++) ref_q[i] <= ref_q[i-1];
        end
    end

    assign head_flag = ref_q[DEC_LATENCY-1][1];
    assign head_bit  = ref_q[DEC_LATENCY-1][0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bit_err_q <= '0;
        else if (accept)
            bit_err_q <= '0;
        else if (head_flag && (head_bit != decoder_i) && (bit_err_q != 16'hFFFF))
            bit_err_q <= bit_err_q + 16'd1;
    end

`ifdef VITERBI_FRAME_CTRL_ERR_INJ_EN
    localparam logic [15:0] ERR_LAST = 16'(ERR_PERIOD - 1);

    logic [15:0] sym_mod_q;   // symbol index modulo ERR_PERIOD
    logic        mask_sel_q;  // 0: next error uses ERR_MASK_A
    logic [1:0]  err_mask_q;
    logic [15:0] inj_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_mod_q  <= '0;
            mask_sel_q <= 1'b0;
            err_mask_q <= 2'b00;
            inj_q      <= '0;
        end else begin
            err_mask_q <= 2'b00;
            if (accept) begin
                sym_mod_q  <= '0;
                mask_sel_q <= 1'b0;
                inj_q      <= '0;
            end else if (enc_en_q) begin
                if (sym_mod_q == ERR_LAST) begin
                    sym_mod_q  <= '0;
                    err_mask_q <= mask_sel_q ? ERR_MASK_B : ERR_MASK_A;
                    mask_sel_q <= ~mask_sel_q;
                    if (inj_q != 16'hFFFF) inj_q <= inj_q + 16'd1;
                end else begin
                    sym_mod_q <= sym_mod_q + 16'd1;
                end
            end
        end
    end

    assign err_mask_o   = err_mask_q;
    assign inj_err_ct_o = inj_q;
`else
    assign err_mask_o   = 2'b00;
    assign inj_err_ct_o = 16'd0;
`endif

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign enc_enable_o = enc_en_q;
    assign enc_data_o   = enc_data_q;
    assign bit_err_ct_o = bit_err_q;

endmodule
